// File: rtl/zbt_sram_model_pkg.sv
// Shared width defaults and command encoding for the ZBT SRAM bank model.
package zbt_sram_model_pkg;

  localparam int ZBT_ADDR_W = 19;
  localparam int ZBT_DATA_W = 36;

  typedef enum logic {
    CMD_RD = 1'b0,
    CMD_WR = 1'b1
  } cmd_e;

  // Anything other than a clean 1 (including X) decodes as a read so a
  // floating command line can never corrupt the array.
  function automatic cmd_e decode_cmd(input logic wr);
    if (wr) return CMD_WR;
    return CMD_RD;
  endfunction

endpackage

// File: rtl/zbt_sram_model.sv
// ZBT synchronous SRAM bank: two-stage command pipeline, one array access per
// edge, registered read data with write-through of the late write data.
module zbt_sram_model
  import zbt_sram_model_pkg::*;
#(
  parameter int ADDR_W = ZBT_ADDR_W,
  parameter int DATA_W = ZBT_DATA_W,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write,
  output logic [DATA_W-1:0] data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cmd_e             s1_cmd, s2_cmd;
  logic [IDX_W-1:0] s1_idx, s2_idx;

  // Array starts cleared and is deliberately left out of the reset domain.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_cmd <= CMD_RD;
      s1_idx <= '0;
      s2_cmd <= CMD_RD;
      s2_idx <= '0;
      data   <= '0;
    end else begin
      s1_cmd <= decode_cmd(wr);
      s1_idx <= addr[IDX_W-1:0];
      s2_cmd <= s1_cmd;
      s2_idx <= s1_idx;
      if (s2_cmd == CMD_WR) data <= write;
      else                  data <= mem[s2_idx];
    end
  end

  always_ff @(posedge clock) begin
    if (reset && (s2_cmd == CMD_WR)) mem[s2_idx] <= write;
  end

endmodule

// File: tb/tb_zbt_sram_model.sv
// Directed bench for zbt_sram_model: reset, pipeline latency, hazards, wrap,
// streaming, interleaving and mid-operation reset.
module tb_zbt_sram_model;

  localparam int AW = 12;
  localparam int DW = 36;
  localparam int DP = 2048;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr    = 1'b0;
  logic [AW-1:0] addr  = '0;
  logic [DW-1:0] write = '0;
  logic [DW-1:0] data;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] pend1 = '0;
  logic [DW-1:0] pend2 = '0;

  zbt_sram_model #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DP)) dut (
    .clock (clock),
    .reset (rst_n),
    .wr    (wr),
    .addr  (addr),
    .write (write),
    .data  (data)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic          chk;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vt[22];

  function automatic logic [DW-1:0] rnd36();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One command cycle; write data for a write command goes on the bus two
  // cycles later. Outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input logic wr_i, input logic [AW-1:0] a_i,
                      input logic [DW-1:0] wd_i);
    wr    = wr_i;
    addr  = a_i;
    write = pend2;
    pend2 = pend1;
    pend1 = wr_i ? wd_i : rnd36();
    @(posedge clock);
    #1;
  endtask

  logic [AW-1:0] ra[3];
  logic [DW-1:0] res[64];

  initial begin
    vt[0]  = '{1'b1, 12'd5,    36'h123456789, 1'b0, 36'h0};
    vt[1]  = '{1'b0, 12'd0,    36'h0,         1'b0, 36'h0};
    vt[2]  = '{1'b0, 12'd0,    36'h0,         1'b1, 36'h123456789};
    vt[3]  = '{1'b0, 12'd5,    36'h0,         1'b1, 36'h0};
    vt[4]  = '{1'b0, 12'd0,    36'h0,         1'b1, 36'h0};
    vt[5]  = '{1'b0, 12'd0,    36'h0,         1'b1, 36'h123456789};
    vt[6]  = '{1'b1, 12'd9,    36'hAA,        1'b1, 36'h0};
    vt[7]  = '{1'b0, 12'd9,    36'h0,         1'b1, 36'h0};
    vt[8]  = '{1'b1, 12'd10,   36'h55,        1'b1, 36'hAA};
    vt[9]  = '{1'b0, 12'd9,    36'h0,         1'b1, 36'hAA};
    vt[10] = '{1'b0, 12'd10,   36'h0,         1'b1, 36'h55};
    vt[11] = '{1'b0, 12'd9,    36'h0,         1'b1, 36'hAA};
    vt[12] = '{1'b0, 12'd5,    36'h0,         1'b1, 36'h55};
    vt[13] = '{1'b0, 12'd2053, 36'h0,         1'b1, 36'hAA};
    vt[14] = '{1'b1, 12'd2058, 36'h77,        1'b1, 36'h123456789};
    vt[15] = '{1'b0, 12'd10,   36'h0,         1'b1, 36'h123456789};
    vt[16] = '{1'b0, 12'd0,    36'h0,         1'b1, 36'h77};
    vt[17] = '{1'b0, 12'd0,    36'h0,         1'b1, 36'h77};
    vt[18] = '{1'b1, 12'd2047, 36'hFFFFFFFFF, 1'b1, 36'h0};
    vt[19] = '{1'b0, 12'd2047, 36'h0,         1'b1, 36'h0};
    vt[20] = '{1'b0, 12'd0,    36'h0,         1'b1, 36'hFFFFFFFFF};
    vt[21] = '{1'b0, 12'd0,    36'h0,         1'b1, 36'hFFFFFFFFF};

    // Reset held with write traffic: output stays 0, nothing is written.
    #1;
    check("reset_t0", data, '0);
    for (int i = 0; i < 3; i++) begin
      ra[i] = 12'($urandom_range(1, DP - 1));
      tick(1'b1, ra[i], rnd36() | 36'h1);
      check("reset_hold", data, '0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) tick(1'b0, ra[i], '0);
      else       tick(1'b0, '0, '0);
      check("reset_readback", data, '0);
    end

    // Directed table: single write/read, RAW hazard, wrap, full-scale data.
    for (int i = 0; i < 22; i++) begin
      tick(vt[i].wr, vt[i].a, vt[i].wd);
      if (vt[i].chk) check($sformatf("vec%0d", i), data, vt[i].exp);
    end

    // Back-to-back write stream then read stream.
    for (int i = 0; i < 2000; i++) begin
      tick(1'b1, 12'(i), 36'(i * 7));
      if (i >= 2) check("stream_wt", data, 36'((i - 2) * 7));
    end
    for (int j = 0; j < 2002; j++) begin
      if (j < 2000) tick(1'b0, 12'(j), '0);
      else          tick(1'b0, '0, '0);
      if (j < 2) check("stream_wt_tail", data, 36'((1998 + j) * 7));
      else       check("stream_rd", data, 36'((j - 2) * 7));
    end

    // Interleaved write a / read a-1.
    tick(1'b1, 12'd2000, 36'(2000 * 8));
    res[0] = 36'(2000 * 8);
    for (int a = 2001; a < 2031; a++) begin
      int n;
      n = 2 * (a - 2001) + 1;
      tick(1'b1, 12'(a), 36'(a * 8));
      res[n] = 36'(a * 8);
      if (n >= 2) check("inter_wt", data, res[n - 2]);
      tick(1'b0, 12'(a - 1), '0);
      res[n + 1] = 36'((a - 1) * 8);
      check("inter_rd", data, res[n - 1]);
    end
    tick(1'b0, '0, '0);
    check("inter_tail0", data, res[59]);
    tick(1'b0, '0, '0);
    check("inter_tail1", data, res[60]);

    // Reset between a write command and its data cycle.
    tick(1'b1, 12'd300, 36'hBEEF);
    rst_n = 1'b0;
    #1;
    check("midrst_async", data, '0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, '0, '0);
      check("midrst_hold", data, '0);
    end
    rst_n = 1'b1;
    tick(1'b0, 12'd300, '0);
    check("midrst_rel1", data, '0);
    tick(1'b0, '0, '0);
    check("midrst_rel2", data, '0);
    tick(1'b0, '0, '0);
    check("midrst_word", data, 36'(300 * 7));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
